// File: rtl/lighthouse_ootx_decoder_pkg.sv
// Shared definitions for the lighthouse OOTX side-channel decoder.
package lighthouse_ootx_decoder_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LENGTH,
        ST_PAYLOAD,
        ST_CRC,
        ST_SYNC
    } ootx_state_e;

    localparam int          OOTX_PREAMBLE_ZEROS  = 17;
    localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT           = 32'hFFFFFFFF;

    // The OOTX length field and CRC words carry little-endian bytes inside big-endian words.
    function automatic logic [15:0] byteSwap16(input logic [15:0] w);
        return {w[7:0], w[15:8]};
    endfunction

endpackage

// File: rtl/lighthouse_ootx_decoder_crc32_byte.sv
// One-byte step of the reflected IEEE CRC-32, fully combinational.
module ootx_crc32_byte
    import lighthouse_ootx_decoder_pkg::*;
(
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] c;

    always_comb begin
        c = crc_i ^ {24'd0, data_i};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFLECTED) : (c >> 1);
        end
        crc_o = c;
    end

endmodule

// File: rtl/lighthouse_ootx_decoder.sv
// Assembles OOTX frames from the per-sweep sync data bit: payload bytes, length and CRC verdict.
module lighthouse_ootx_decoder
    import lighthouse_ootx_decoder_pkg::*;
#(
    parameter int MAX_LEN = 64
) (
    input  logic        clk_48,
    input  logic        reset,
    input  logic        bit_strobe,
    input  logic        bit_data,
    output logic [7:0]  byte_data,
    output logic        byte_strobe,
    output logic        frame_start,
    output logic [15:0] frame_len,
    output logic        frame_done,
    output logic        crc_ok,
    output logic        frame_error
);

    localparam int WORD_CNT_W = $clog2((MAX_LEN + 1) / 2 + 3);
    localparam int ZERO_CNT_W = $clog2(OOTX_PREAMBLE_ZEROS + 1);

    ootx_state_e           state_q, state_d;
    logic [ZERO_CNT_W-1:0] zeroCnt_q, zeroCnt_d;
    logic [3:0]            bitCnt_q, bitCnt_d;
    logic [WORD_CNT_W-1:0] wordCnt_q, wordCnt_d;
    logic [15:0]           byteCnt_q, byteCnt_d;
    logic [15:0]           shift_q, shift_d;
    logic [15:0]           crcWord0_q, crcWord0_d;
    logic [31:0]           crc_q, crc_d;
    logic [7:0]            byteData_q, byteData_d;
    logic                  byteStrobe_q, byteStrobe_d;
    logic                  frameStart_q, frameStart_d;
    logic [15:0]           frameLen_q, frameLen_d;
    logic                  frameDone_q, frameDone_d;
    logic                  crcOk_q, crcOk_d;
    logic                  frameError_q, frameError_d;

    logic [15:0] shiftNext;
    logic [15:0] lenVal;
    logic [31:0] crcNext;
    logic [31:0] crcReceived;
    logic [16:0] payloadWords;
    logic [16:0] wordCntExt;

    assign shiftNext    = {shift_q[14:0], bit_data};
    assign lenVal       = byteSwap16(shiftNext);
    assign crcReceived  = {byteSwap16(shiftNext), byteSwap16(crcWord0_q)};
    assign payloadWords = ({1'b0, frameLen_q} + 17'd1) >> 1;
    assign wordCntExt   = {{(17 - WORD_CNT_W){1'b0}}, wordCnt_q};

    // Every emitted byte is the low byte of the freshly shifted word, so one CRC step suffices.
    ootx_crc32_byte u_crc (
        .crc_i  (crc_q),
        .data_i (shiftNext[7:0]),
        .crc_o  (crcNext)
    );

    always_ff @(posedge clk_48) begin
        if (reset) begin
            state_q      <= ST_HUNT;
            zeroCnt_q    <= '0;
            bitCnt_q     <= '0;
            wordCnt_q    <= '0;
            byteCnt_q    <= '0;
            shift_q      <= '0;
            crcWord0_q   <= '0;
            crc_q        <= CRC32_INIT;
            byteData_q   <= '0;
            byteStrobe_q <= 1'b0;
            frameStart_q <= 1'b0;
            frameLen_q   <= '0;
            frameDone_q  <= 1'b0;
            crcOk_q      <= 1'b0;
            frameError_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            zeroCnt_q    <= zeroCnt_d;
            bitCnt_q     <= bitCnt_d;
            wordCnt_q    <= wordCnt_d;
            byteCnt_q    <= byteCnt_d;
            shift_q      <= shift_d;
            crcWord0_q   <= crcWord0_d;
            crc_q        <= crc_d;
            byteData_q   <= byteData_d;
            byteStrobe_q <= byteStrobe_d;
            frameStart_q <= frameStart_d;
            frameLen_q   <= frameLen_d;
            frameDone_q  <= frameDone_d;
            crcOk_q      <= crcOk_d;
            frameError_q <= frameError_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        zeroCnt_d    = zeroCnt_q;
        bitCnt_d     = bitCnt_q;
        wordCnt_d    = wordCnt_q;
        byteCnt_d    = byteCnt_q;
        shift_d      = shift_q;
        crcWord0_d   = crcWord0_q;
        crc_d        = crc_q;
        byteData_d   = byteData_q;
        byteStrobe_d = 1'b0;
        frameStart_d = 1'b0;
        frameLen_d   = frameLen_q;
        frameDone_d  = 1'b0;
        crcOk_d      = crcOk_q;
        frameError_d = 1'b0;

        if (bit_strobe) begin
            case (state_q)
                ST_HUNT: begin
                    if (!bit_data) begin
                        if (zeroCnt_q < ZERO_CNT_W'(OOTX_PREAMBLE_ZEROS)) begin
                            zeroCnt_d = zeroCnt_q + 1'b1;
                        end
                    end else if (zeroCnt_q >= ZERO_CNT_W'(OOTX_PREAMBLE_ZEROS)) begin
                        state_d   = ST_LENGTH;
                        zeroCnt_d = '0;
                        bitCnt_d  = '0;
                    end else begin
                        zeroCnt_d = '0;
                    end
                end
                ST_LENGTH: begin
                    shift_d  = shiftNext;
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd15) begin
                        bitCnt_d = '0;
                        if (lenVal > 16'(MAX_LEN)) begin
                            frameError_d = 1'b1;
                            state_d      = ST_HUNT;
                        end else begin
                            frameStart_d = 1'b1;
                            frameLen_d   = lenVal;
                            wordCnt_d    = '0;
                            byteCnt_d    = '0;
                            crc_d        = CRC32_INIT;
                            state_d      = ST_SYNC;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    shift_d  = shiftNext;
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd7) begin
                        byteData_d   = shiftNext[7:0];
                        byteStrobe_d = 1'b1;
                        crc_d        = crcNext;
                        byteCnt_d    = byteCnt_q + 16'd1;
                    end
                    if (bitCnt_q == 4'd15) begin
                        bitCnt_d  = '0;
                        wordCnt_d = wordCnt_q + 1'b1;
                        state_d   = ST_SYNC;
                        // An odd-length frame ends with a pad byte that must not reach the FIFO or CRC.
                        if (byteCnt_q < frameLen_q) begin
                            byteData_d   = shiftNext[7:0];
                            byteStrobe_d = 1'b1;
                            crc_d        = crcNext;
                            byteCnt_d    = byteCnt_q + 16'd1;
                        end
                    end
                end
                ST_CRC: begin
                    shift_d  = shiftNext;
                    bitCnt_d = bitCnt_q + 4'd1;
                    if (bitCnt_q == 4'd15) begin
                        bitCnt_d  = '0;
                        wordCnt_d = wordCnt_q + 1'b1;
                        if (wordCntExt == payloadWords) begin
                            crcWord0_d = shiftNext;
                            state_d    = ST_SYNC;
                        end else begin
                            frameDone_d = 1'b1;
                            crcOk_d     = ((crc_q ^ CRC32_INIT) == crcReceived);
                            zeroCnt_d   = '0;
                            state_d     = ST_HUNT;
                        end
                    end
                end
                ST_SYNC: begin
                    bitCnt_d = '0;
                    if (!bit_data) begin
                        frameError_d = 1'b1;
                        zeroCnt_d    = '0;
                        state_d      = ST_HUNT;
                    end else if (wordCntExt < payloadWords) begin
                        state_d = ST_PAYLOAD;
                    end else begin
                        state_d = ST_CRC;
                    end
                end
                default: begin
                    state_d   = ST_HUNT;
                    zeroCnt_d = '0;
                end
            endcase
        end
    end

    assign byte_data   = byteData_q;
    assign byte_strobe = byteStrobe_q;
    assign frame_start = frameStart_q;
    assign frame_len   = frameLen_q;
    assign frame_done  = frameDone_q;
    assign crc_ok      = crcOk_q;
    assign frame_error = frameError_q;

endmodule

// File: tb/tb_lighthouse_ootx_decoder.sv
// Directed bench for the OOTX decoder: good/corrupt/aborted frames, length limits, strobe pacing.
module tb_lighthouse_ootx_decoder;

    logic        clk_48 = 1'b0;
    logic        reset;
    logic        bit_strobe;
    logic        bit_data;
    logic [7:0]  byte_data;
    logic        byte_strobe;
    logic        frame_start;
    logic [15:0] frame_len;
    logic        frame_done;
    logic        crc_ok;
    logic        frame_error;

    int nChecks = 0;
    int nFails  = 0;
    int gapCycles = 2;
    int cycle = 0;

    int byteCount, startCount, doneCount, errorCount, overlapCount;
    int lastByteCycle, doneCycle;
    logic lastCrcOk;
    logic [7:0] capBytes [0:63];

    logic [15:0] frameWords [0:7];
    int nFrameWords;

    lighthouse_ootx_decoder #(.MAX_LEN(64)) dut (
        .clk_48      (clk_48),
        .reset       (reset),
        .bit_strobe  (bit_strobe),
        .bit_data    (bit_data),
        .byte_data   (byte_data),
        .byte_strobe (byte_strobe),
        .frame_start (frame_start),
        .frame_len   (frame_len),
        .frame_done  (frame_done),
        .crc_ok      (crc_ok),
        .frame_error (frame_error)
    );

    always #5 clk_48 = ~clk_48;

    // Collect output pulses shortly after each clock edge.
    always @(posedge clk_48) begin
        cycle++;
        #1;
        if (byte_strobe === 1'b1) begin
            if (byteCount < 64) capBytes[byteCount] = byte_data;
            byteCount++;
            lastByteCycle = cycle;
        end
        if (frame_start === 1'b1) startCount++;
        if (frame_error === 1'b1) errorCount++;
        if (frame_start === 1'b1 && frame_error === 1'b1) overlapCount++;
        if (frame_done === 1'b1) begin
            doneCount++;
            doneCycle = cycle;
            lastCrcOk = crc_ok;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearMonitor();
        byteCount = 0; startCount = 0; doneCount = 0; errorCount = 0;
        lastByteCycle = 0; doneCycle = 0; lastCrcOk = 1'b0;
    endtask

    // Presents one bit for exactly one rising edge; returns on the following falling edge.
    task automatic applyStimulus(input logic b);
        repeat (gapCycles) @(negedge clk_48);
        bit_strobe = 1'b1;
        bit_data   = b;
        @(negedge clk_48);
        bit_strobe = 1'b0;
        bit_data   = 1'($urandom_range(0, 1));
    endtask

    task automatic sendPreamble(input int zeros);
        for (int i = 0; i < zeros; i++) applyStimulus(1'b0);
        applyStimulus(1'b1);
    endtask

    task automatic sendWord(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) applyStimulus(w[i]);
    endtask

    task automatic sendFrame();
        sendPreamble(17);
        for (int i = 0; i < nFrameWords; i++) begin
            sendWord(frameWords[i]);
            applyStimulus(1'b1);
        end
    endtask

    task automatic loadGoodFrame();
        frameWords[0] = 16'h0900;
        frameWords[1] = 16'h3132;
        frameWords[2] = 16'h3334;
        frameWords[3] = 16'h3536;
        frameWords[4] = 16'h3738;
        frameWords[5] = 16'h3900;
        frameWords[6] = 16'h2639;
        frameWords[7] = 16'hF4CB;
        nFrameWords   = 8;
    endtask

    task automatic checkGoodFrame(input string pfx);
        logic [7:0] expByte;
        checkOutput({pfx, "_byte_count"}, byteCount, 9);
        for (int i = 0; i < 9; i++) begin
            expByte = 8'h31 + 8'(i);
            checkOutput($sformatf("%s_byte%0d", pfx, i), {24'd0, capBytes[i]}, {24'd0, expByte});
        end
        checkOutput({pfx, "_starts"}, startCount, 1);
        checkOutput({pfx, "_frame_len"}, {16'd0, frame_len}, 32'd9);
        checkOutput({pfx, "_dones"}, doneCount, 1);
        checkOutput({pfx, "_crc_ok"}, {31'd0, lastCrcOk}, 32'd1);
        checkOutput({pfx, "_errors"}, errorCount, 0);
        checkOutput({pfx, "_last_byte_before_done"}, {31'd0, (doneCycle > lastByteCycle)}, 32'd1);
    endtask

    task automatic checkOutputsCleared(input string pfx);
        checkOutput({pfx, "_byte_data"}, {24'd0, byte_data}, 32'd0);
        checkOutput({pfx, "_byte_strobe"}, {31'd0, byte_strobe}, 32'd0);
        checkOutput({pfx, "_frame_start"}, {31'd0, frame_start}, 32'd0);
        checkOutput({pfx, "_frame_len"}, {16'd0, frame_len}, 32'd0);
        checkOutput({pfx, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        checkOutput({pfx, "_crc_ok"}, {31'd0, crc_ok}, 32'd0);
        checkOutput({pfx, "_frame_error"}, {31'd0, frame_error}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bit_strobe = 1'b0;
        bit_data = 1'b0;
        overlapCount = 0;
        clearMonitor();
        repeat (3) @(negedge clk_48);
        checkOutputsCleared("reset");
        reset = 1'b0;
        @(negedge clk_48);

        $display("[TB] standard frame, slow strobes");
        loadGoodFrame();
        clearMonitor();
        sendFrame();
        checkGoodFrame("std");

        $display("[TB] corrupted payload bit");
        frameWords[1] = 16'h3133;
        clearMonitor();
        sendFrame();
        checkOutput("flip_byte_count", byteCount, 9);
        checkOutput("flip_dones", doneCount, 1);
        checkOutput("flip_crc_ok", {31'd0, lastCrcOk}, 32'd0);

        $display("[TB] bad sync after second payload word");
        loadGoodFrame();
        clearMonitor();
        sendPreamble(17);
        sendWord(16'h0900); applyStimulus(1'b1);
        sendWord(16'h3132); applyStimulus(1'b1);
        sendWord(16'h3334); applyStimulus(1'b0);
        checkOutput("badsync_errors", errorCount, 1);
        checkOutput("badsync_dones", doneCount, 0);
        checkOutput("badsync_bytes", byteCount, 4);
        clearMonitor();
        sendFrame();
        checkGoodFrame("after_badsync");

        $display("[TB] oversize and maximum length");
        clearMonitor();
        sendPreamble(17);
        sendWord(16'h4100);
        checkOutput("oversize_error_pulse", {31'd0, frame_error}, 32'd1);
        checkOutput("oversize_no_start", {31'd0, frame_start}, 32'd0);
        @(negedge clk_48);
        checkOutput("oversize_error_one_cycle", {31'd0, frame_error}, 32'd0);
        checkOutput("oversize_starts", startCount, 0);
        checkOutput("oversize_len_held", {16'd0, frame_len}, 32'd9);
        clearMonitor();
        sendPreamble(17);
        sendWord(16'h4000);
        checkOutput("maxlen_start_pulse", {31'd0, frame_start}, 32'd1);
        checkOutput("maxlen_frame_len", {16'd0, frame_len}, 32'd64);
        checkOutput("maxlen_errors", errorCount, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk_48);
        reset = 1'b0;

        $display("[TB] zero-length frame");
        frameWords[0] = 16'h0000;
        frameWords[1] = 16'h0000;
        frameWords[2] = 16'h0000;
        nFrameWords   = 3;
        clearMonitor();
        sendFrame();
        checkOutput("len0_bytes", byteCount, 0);
        checkOutput("len0_starts", startCount, 1);
        checkOutput("len0_dones", doneCount, 1);
        checkOutput("len0_crc_ok", {31'd0, lastCrcOk}, 32'd1);

        $display("[TB] short preamble then proper lock");
        loadGoodFrame();
        clearMonitor();
        sendPreamble(16);
        sendWord(16'h0900); applyStimulus(1'b1);
        checkOutput("short_preamble_starts", startCount, 0);
        sendFrame();
        checkGoodFrame("after_short");

        $display("[TB] back-to-back strobes");
        gapCycles = 0;
        clearMonitor();
        sendFrame();
        checkGoodFrame("b2b");

        $display("[TB] reset mid-payload");
        gapCycles = 1;
        clearMonitor();
        sendPreamble(17);
        sendWord(16'h0900); applyStimulus(1'b1);
        sendWord(16'h3132); applyStimulus(1'b1);
        for (int i = 15; i >= 8; i--) applyStimulus(frameWords[2][i]);
        reset = 1'b1;
        repeat (2) @(negedge clk_48);
        checkOutputsCleared("midreset");
        reset = 1'b0;
        checkOutput("midreset_dones", doneCount, 0);
        checkOutput("midreset_errors", errorCount, 0);
        clearMonitor();
        sendFrame();
        checkGoodFrame("after_reset");

        checkOutput("start_error_overlap", overlapCount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
